// File: rtl/mp_add_sequencer_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mp_add_pkg
// Brief    : Shared state encoding, default widths and limb-count helper for
//            the multi-precision add/subtract sequencer.
// Revision : 1.0 - initial release
//==============================================================================
package mp_add_pkg;

    localparam int c_def_operand_width = 256;
    localparam int c_def_adder_width   = 64;
    localparam int c_cla_group         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Returns 0 for an illegal width pairing so the caller can flag it at elaboration.
    function automatic int num_limbs(input int operand_width, input int adder_width);
        if ((adder_width < c_cla_group) || ((adder_width % c_cla_group) != 0) ||
            (operand_width < adder_width) || ((operand_width % adder_width) != 0))
            return 0;
        return operand_width / adder_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mp_add_sequencer_limb_adder.sv
`default_nettype none
//==============================================================================
// Module   : mp_limb_adder
// Brief    : Combinational limb adder built from 8-bit carry-lookahead groups
//            chained through the group carry.
// Revision : 1.0 - initial release
//==============================================================================
module mp_limb_adder
    import mp_add_pkg::*;
#(
    parameter int ADDER_WIDTH = c_def_adder_width
) (
    input  logic [ADDER_WIDTH-1:0] a,
    input  logic [ADDER_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [ADDER_WIDTH-1:0] sum,
    output logic                   cout
);

    localparam int c_num_groups = ADDER_WIDTH / c_cla_group;

    logic [ADDER_WIDTH-1:0] w_gen;
    logic [ADDER_WIDTH-1:0] w_prop;
    logic [c_cla_group:0]   w_grp_c;
    logic                   w_gc;
    logic                   w_term;

    always_comb begin
        w_gen   = a & b;
        w_prop  = a ^ b;
        sum     = '0;
        w_gc    = cin;
        w_grp_c = '0;
        w_term  = 1'b0;
        for (int gi = 0; gi < c_num_groups; gi++) begin
            w_grp_c[0] = w_gc;
            // Each in-group carry is a flat sum-of-products of G/P and the group carry-in.
            for (int k = 1; k <= c_cla_group; k++) begin
                w_term = w_gc;
                for (int m = 0; m < k; m++)
                    w_term = w_term & w_prop[gi*c_cla_group + m];
                w_grp_c[k] = w_term;
                for (int j = 0; j < k; j++) begin
                    w_term = w_gen[gi*c_cla_group + j];
                    for (int m = j + 1; m < k; m++)
                        w_term = w_term & w_prop[gi*c_cla_group + m];
                    w_grp_c[k] = w_grp_c[k] | w_term;
                end
            end
            for (int k = 0; k < c_cla_group; k++)
                sum[gi*c_cla_group + k] = w_prop[gi*c_cla_group + k] ^ w_grp_c[k];
            w_gc = w_grp_c[c_cla_group];
        end
        cout = w_gc;
    end

endmodule
`default_nettype wire

// File: rtl/mp_add_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : mp_add_sequencer
// Brief    : Wide add/subtract pushed LSB-first, one limb per cycle, through a
//            single shared limb adder with a registered inter-limb carry.
// Revision : 1.0 - initial release
//==============================================================================
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int OPERAND_WIDTH = c_def_operand_width,
    parameter int ADDER_WIDTH   = c_def_adder_width
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_a,
    input  logic [OPERAND_WIDTH-1:0] in_b,
    input  logic                     in_sub,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_sum,
    output logic                     out_cout,
    output logic                     busy
);

    localparam int NUM_LIMBS = num_limbs(OPERAND_WIDTH, ADDER_WIDTH);
    localparam int c_idx_w   = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_LIMBS - 1);

    if (NUM_LIMBS < 1) begin : g_width_check
        $error("mp_add_sequencer: OPERAND_WIDTH must be a multiple of ADDER_WIDTH, ADDER_WIDTH a multiple of 8");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;
    logic                   w_run;
    logic [c_idx_w-1:0]     r_idx;
    logic                   r_carry;
    logic                   r_sub;
    logic [ADDER_WIDTH-1:0] r_a_limb   [NUM_LIMBS];
    logic [ADDER_WIDTH-1:0] r_b_limb   [NUM_LIMBS];
    logic [ADDER_WIDTH-1:0] r_sum_limb [NUM_LIMBS];
    logic [ADDER_WIDTH-1:0] w_limb_sum;
    logic                   w_limb_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                w_run = 1'b1;
                if (r_idx == c_last_idx)
                    w_state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Subtraction is folded into the add: B is inverted at capture and the
    // borrow-in is turned into a carry-in so the limb adder never sees in_sub.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            for (int i = 0; i < NUM_LIMBS; i++) begin
                r_a_limb[i]   <= '0;
                r_b_limb[i]   <= '0;
                r_sum_limb[i] <= '0;
            end
        end else if (w_accept) begin
            r_idx   <= '0;
            r_carry <= in_cin ^ in_sub;
            r_sub   <= in_sub;
            for (int i = 0; i < NUM_LIMBS; i++) begin
                r_a_limb[i] <= in_a[i*ADDER_WIDTH +: ADDER_WIDTH];
                r_b_limb[i] <= in_sub ? ~in_b[i*ADDER_WIDTH +: ADDER_WIDTH]
                                      :  in_b[i*ADDER_WIDTH +: ADDER_WIDTH];
            end
        end else if (w_run) begin
            r_sum_limb[r_idx] <= w_limb_sum;
            r_carry           <= w_limb_cout;
            if (r_idx != c_last_idx)
                r_idx <= r_idx + 1'b1;
        end
    end

    mp_limb_adder #(
        .ADDER_WIDTH (ADDER_WIDTH)
    ) u_limb_adder (
        .a    (r_a_limb[r_idx]),
        .b    (r_b_limb[r_idx]),
        .cin  (r_carry),
        .sum  (w_limb_sum),
        .cout (w_limb_cout)
    );

    for (genvar gi = 0; gi < NUM_LIMBS; gi++) begin : g_out_limb
        assign out_sum[gi*ADDER_WIDTH +: ADDER_WIDTH] = r_sum_limb[gi];
    end

    // The raw carry of an inverted-B add is the complement of the borrow.
    assign out_cout = r_carry ^ r_sub;

endmodule
`default_nettype wire

// File: tb/tb_mp_add_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_mp_add_sequencer
// Brief    : Scoreboard bench for mp_add_sequencer with default widths.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mp_add_sequencer;

    localparam int c_ow      = 256;
    localparam int c_aw      = 64;
    localparam int c_nl      = c_ow / c_aw;
    localparam int c_timeout = 50;

    typedef struct packed {
        logic [c_ow-1:0] sum;
        logic            cout;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [c_ow-1:0] in_a;
    logic [c_ow-1:0] in_b;
    logic            in_sub;
    logic            in_cin;
    logic            out_valid;
    logic            out_ready;
    logic [c_ow-1:0] out_sum;
    logic            out_cout;
    logic            busy;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mp_add_sequencer #(
        .OPERAND_WIDTH (c_ow),
        .ADDER_WIDTH   (c_aw)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [c_ow:0] obs, input logic [c_ow:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: plain add, or true subtraction with borrow from a compare.
    function automatic exp_t model(input logic [c_ow-1:0] a, input logic [c_ow-1:0] b,
                                   input logic sub, input logic cin);
        exp_t            e;
        logic [c_ow:0]   t;
        if (!sub) begin
            t      = {1'b0, a} + {1'b0, b} + (c_ow+1)'(cin);
            e.sum  = t[c_ow-1:0];
            e.cout = t[c_ow];
        end else begin
            e.sum  = a - b - c_ow'(cin);
            e.cout = ({1'b0, a} < ({1'b0, b} + (c_ow+1)'(cin)));
        end
        return e;
    endfunction

    task automatic send(input logic [c_ow-1:0] a, input logic [c_ow-1:0] b,
                        input logic sub, input logic cin);
        int n;
        n = 0;
        while (!in_ready && n < c_timeout) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", (c_ow+1)'(in_ready), (c_ow+1)'(1));
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        in_valid = 1'b1;
        sb.push_back(model(a, b, sub, cin));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!out_valid && k < c_timeout);
        check({tag, "_lat"},  (c_ow+1)'(k),    (c_ow+1)'(c_nl));
        check({tag, "_busy"}, (c_ow+1)'(busy), (c_ow+1)'(1));
    endtask

    task automatic collect(input string tag);
        exp_t e;
        wait_valid(tag);
        e = sb.pop_front();
        check({tag, "_sum"},  (c_ow+1)'(out_sum),  (c_ow+1)'(e.sum));
        check({tag, "_cout"}, (c_ow+1)'(out_cout), (c_ow+1)'(e.cout));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, (c_ow+1)'({in_ready, out_valid}), (c_ow+1)'(2'b10));
    endtask

    initial begin
        logic [c_ow-1:0] all_ones;
        logic [c_ow-1:0] p64;
        logic [c_ow-1:0] ra;
        logic [c_ow-1:0] rb;
        exp_t            e;
        logic            seen_valid;

        all_ones  = '1;
        p64       = '0;
        p64[64]   = 1'b1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  (c_ow+1)'(in_ready),  (c_ow+1)'(1));
        check("rst_out_valid", (c_ow+1)'(out_valid), (c_ow+1)'(0));
        check("rst_out_sum",   (c_ow+1)'(out_sum),   (c_ow+1)'(0));
        check("rst_out_cout",  (c_ow+1)'(out_cout),  (c_ow+1)'(0));
        check("rst_busy",      (c_ow+1)'(busy),      (c_ow+1)'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Full carry ripple across every limb.
        send(all_ones, c_ow'(1), 1'b0, 1'b0);
        collect("add_wrap");
        check("add_wrap_abs", (c_ow+1)'({out_cout, out_sum}), {1'b1, {c_ow{1'b0}}});

        send('0, c_ow'(1), 1'b1, 1'b0);
        collect("sub_borrow");
        check("sub_borrow_abs", (c_ow+1)'({out_cout, out_sum}), {1'b1, all_ones});

        send(c_ow'(5), c_ow'(3), 1'b1, 1'b0);
        collect("sub_5m3");
        check("sub_5m3_abs", (c_ow+1)'(out_sum), (c_ow+1)'(2));
        send(c_ow'(5), c_ow'(3), 1'b1, 1'b1);
        collect("sub_5m3_bin");
        check("sub_5m3_bin_abs", (c_ow+1)'(out_sum), (c_ow+1)'(1));

        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send(ra, rb, 1'(i), 1'(i >> 1));
            collect("rand");
        end

        // Back-pressure in DONE while the source keeps poking in_valid.
        send({4{64'h0123_4567_89ab_cdef}}, {4{64'hfedc_ba98_7654_3210}}, 1'b0, 1'b1);
        wait_valid("hold");
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            in_a     = {8{$urandom}};
            in_b     = {8{$urandom}};
            @(posedge clk); #1;
            check("hold_sum",  (c_ow+1)'({out_cout, out_sum}), (c_ow+1)'({e.cout, e.sum}));
            check("hold_ctrl", (c_ow+1)'({in_ready, out_valid}), (c_ow+1)'(2'b01));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release", (c_ow+1)'({in_ready, out_valid}), (c_ow+1)'(2'b10));
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_accept", (c_ow+1)'({busy, in_ready}), (c_ow+1)'(2'b01));

        // Reset while limb 2 is next to be processed; the op must vanish.
        send(all_ones, all_ones, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", (c_ow+1)'({busy, in_ready, out_valid}), (c_ow+1)'(3'b010));
        check("rst_mid_sum",  (c_ow+1)'(out_sum), (c_ow+1)'(0));
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        check("rst_mid_no_valid", (c_ow+1)'({seen_valid, in_ready}), (c_ow+1)'(2'b01));

        send(p64, p64 - c_ow'(1), 1'b0, 1'b0);
        collect("post_rst");
        check("post_rst_abs", (c_ow+1)'({out_cout, out_sum}), (c_ow+1)'((p64 << 1) - c_ow'(1)));

        check("sb_empty", (c_ow+1)'(sb.size()), (c_ow+1)'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
